// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single main-memory port.
// Accepts one request per cycle, issues it for one cycle, returns the response one cycle later.
module mem_arbiter #(
  parameter logic [31:0] OFFSET       = 32'h80020000,
  parameter int unsigned MEMORY_DEPTH = 1048576,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [1:0]  dm_size,
  output logic        dm_gnt,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_access_size,
  output logic        mem_write_enable,
  input  logic [31:0] mem_data_out
);

  localparam int unsigned SW = (STARVE_LIMIT < 4) ? 2 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [33:0] LAST_BYTE = 34'(OFFSET) + 34'(MEMORY_DEPTH) - 34'd1;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  // A request is legal when sized, aligned and fully inside the memory window.
  function automatic logic is_legal(input logic [31:0] addr, input logic [1:0] size);
    logic [2:0]  nb;
    logic        aligned;
    logic [33:0] last;
    nb      = 3'd1;
    aligned = 1'b0;
    case (size)
      2'b01:   begin nb = 3'd1; aligned = 1'b1; end
      2'b10:   begin nb = 3'd2; aligned = ~addr[0]; end
      2'b11:   begin nb = 3'd4; aligned = (addr[1:0] == 2'b00); end
      default: begin nb = 3'd1; aligned = 1'b0; end
    endcase
    last = {2'b00, addr} + 34'(nb) - 34'd1;
    return aligned && (addr >= OFFSET) && (last <= LAST_BYTE);
  endfunction

  logic [SW-1:0] starve_cnt;
  logic          iss_valid;
  logic          iss_dm;
  logic          iss_err;
  logic [1:0]    iss_size;
  logic          we_q;

  logic          acc_valid;
  logic          acc_legal;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [1:0]    acc_size;
  logic [31:0]   rd_ext;

  // Data port wins contention unless the fetch port has lost STARVE_LIMIT times in a row.
  assign if_gnt = ~reset & if_req & (~dm_req | (starve_cnt == STARVE_MAX));
  assign dm_gnt = ~reset & dm_req & ~if_gnt;

  // Reset kills an in-flight write before it reaches memory.
  assign mem_write_enable = we_q & ~reset;

  always_comb begin
    acc_valid = if_gnt | dm_gnt;
    acc_addr  = if_addr;
    acc_size  = SIZE_WORD;
    acc_we    = 1'b0;
    acc_wdata = 32'd0;
    if (dm_gnt) begin
      acc_addr  = dm_addr;
      acc_size  = dm_size;
      acc_we    = dm_we;
      acc_wdata = dm_we ? dm_wdata : 32'd0;
    end
    acc_legal = is_legal(acc_addr, acc_size);
  end

  always_comb begin
    case (iss_size)
      2'b01:   rd_ext = {24'd0, mem_data_out[7:0]};
      2'b10:   rd_ext = {16'd0, mem_data_out[15:0]};
      default: rd_ext = mem_data_out;
    endcase
  end

  // Issue stage: illegal requests travel down the pipe but leave memory idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt      <= '0;
      iss_valid       <= 1'b0;
      iss_dm          <= 1'b0;
      iss_err         <= 1'b0;
      iss_size        <= SIZE_WORD;
      we_q            <= 1'b0;
      mem_address     <= 32'd0;
      mem_data_in     <= 32'd0;
      mem_access_size <= SIZE_WORD;
    end else begin
      if (if_gnt) begin
        starve_cnt <= '0;
      end else if (if_req && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
      iss_valid <= acc_valid;
      iss_dm    <= dm_gnt;
      iss_err   <= ~acc_legal;
      iss_size  <= acc_size;
      if (acc_valid && acc_legal) begin
        mem_address     <= acc_addr;
        mem_data_in     <= acc_wdata;
        mem_access_size <= acc_size;
        we_q            <= acc_we;
      end else begin
        mem_address     <= 32'd0;
        mem_data_in     <= 32'd0;
        mem_access_size <= SIZE_WORD;
        we_q            <= 1'b0;
      end
    end
  end

  // Response stage: capture memory data for the issuing port; rdata holds between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= 32'd0;
      dm_done   <= 1'b0;
      dm_err    <= 1'b0;
      dm_rdata  <= 32'd0;
    end else begin
      if_rvalid <= iss_valid & ~iss_dm;
      if_err    <= iss_valid & ~iss_dm & iss_err;
      dm_done   <= iss_valid & iss_dm;
      dm_err    <= iss_valid & iss_dm & iss_err;
      if (iss_valid && !iss_dm) begin
        if_rdata <= iss_err ? 32'd0 : mem_data_out;
      end
      if (iss_valid && iss_dm) begin
        dm_rdata <= (iss_err || we_q) ? 32'd0 : rd_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte-array main memory, request/response
// scoreboard model, directed scenarios followed by randomized traffic.
module tb_mem_arbiter;

  localparam logic [31:0] OFFSET = 32'h80020000;
  localparam int unsigned DEPTH  = 1048576;
  localparam int          LIMIT  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_done, dm_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [1:0]  dm_size;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic [1:0]  mem_access_size;
  logic        mem_write_enable;

  always #5 clk = ~clk;

  mem_arbiter #(.OFFSET(OFFSET), .MEMORY_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_size(dm_size), .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .dm_err(dm_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_access_size(mem_access_size), .mem_write_enable(mem_write_enable),
    .mem_data_out(mem_data_out)
  );

  typedef struct packed {
    int          due;
    logic        dm;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct packed {
    logic        v;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } iss_t;

  int checks = 0;
  int errors = 0;
  int t = 0;
  int streak = 0;
  resp_t q[$];
  iss_t  iss = '0;
  logic [31:0] last_if = 32'd0;
  logic [31:0] last_dm = 32'd0;
  logic seen_if_gnt = 1'b0;
  logic seen_dm_gnt = 1'b0;

  logic [7:0] mem    [int unsigned];
  logic [7:0] shadow [int unsigned];

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'd1: return 1;
      2'd2: return 2;
      2'd3: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit legal(input logic [31:0] a, input logic [1:0] s);
    longint n, aa;
    n  = longint'(nbytes(s));
    aa = longint'({32'd0, a});
    if (n == 0) return 1'b0;
    if (aa < longint'({32'd0, OFFSET})) return 1'b0;
    if (aa + n - 1 > longint'({32'd0, OFFSET}) + longint'(DEPTH) - 1) return 1'b0;
    if (aa % n != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Big-endian, right-justified access to either the bench memory or the model's copy.
  function automatic logic [31:0] rd(input bit sh, input logic [31:0] a, input logic [1:0] s);
    logic [31:0] r;
    logic [7:0]  b;
    int unsigned k;
    r = 32'd0;
    for (int i = 0; i < nbytes(s); i++) begin
      k = a + 32'(i);
      if (sh) b = shadow.exists(k) ? shadow[k] : 8'h00;
      else    b = mem.exists(k) ? mem[k] : 8'h00;
      r = (r << 8) | {24'd0, b};
    end
    return r;
  endfunction

  function automatic void wr(input bit sh, input logic [31:0] a, input logic [1:0] s,
                             input logic [31:0] d);
    int unsigned k;
    int          n;
    n = nbytes(s);
    for (int i = 0; i < n; i++) begin
      k = a + 32'(i);
      if (sh) shadow[k] = 8'(d >> (8 * (n - 1 - i)));
      else    mem[k]    = 8'(d >> (8 * (n - 1 - i)));
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, t);
    end
  endtask

  // One clock cycle: drive inputs, serve memory, compare against the model, advance the model.
  task automatic cycle(input logic rst, input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic dwe, input logic [31:0] daddr,
                       input logic [31:0] dwdata, input logic [1:0] dsize);
    resp_t r, nr;
    iss_t  ni;
    bit    got, eg_if, eg_dm, lg;
    reset = rst; if_req = ireq; if_addr = iaddr;
    dm_req = dreq; dm_we = dwe; dm_addr = daddr; dm_wdata = dwdata; dm_size = dsize;
    #1;
    if (mem_write_enable) wr(1'b0, mem_address, mem_access_size, mem_data_in);
    mem_data_out = rd(1'b0, mem_address, mem_access_size);
    if (iss.v && iss.we && !rst) wr(1'b1, iss.addr, iss.size, iss.wdata);

    eg_if = 1'b0;
    eg_dm = 1'b0;
    if (!rst) begin
      if (ireq && dreq) begin
        if (streak == LIMIT) eg_if = 1'b1;
        else eg_dm = 1'b1;
      end else begin
        eg_if = ireq;
        eg_dm = dreq;
      end
    end

    if (t > 0) begin
      chk("if_gnt", if_gnt, eg_if);
      chk("dm_gnt", dm_gnt, eg_dm);
      chk("mem_write_enable", mem_write_enable, iss.v && iss.we && !rst);
      chk("mem_address", mem_address, iss.v ? iss.addr : 32'd0);
      chk("mem_access_size", mem_access_size, iss.v ? iss.size : 2'b11);
      if (!iss.v || iss.we) chk("mem_data_in", mem_data_in, iss.v ? iss.wdata : 32'd0);
      got = 1'b0;
      r   = '0;
      if (q.size() > 0 && q[0].due == t) begin
        r   = q.pop_front();
        got = 1'b1;
      end
      if (got && !r.dm) last_if = r.rdata;
      if (got && r.dm)  last_dm = r.rdata;
      chk("if_rvalid", if_rvalid, got && !r.dm);
      chk("if_err", if_err, got && !r.dm && r.err);
      chk("if_rdata", if_rdata, last_if);
      chk("dm_done", dm_done, got && r.dm);
      chk("dm_err", dm_err, got && r.dm && r.err);
      chk("dm_rdata", dm_rdata, last_dm);
    end
    seen_if_gnt = if_gnt;
    seen_dm_gnt = dm_gnt;

    nr = '0;
    ni = '0;
    lg = 1'b0;
    if (eg_if || eg_dm) begin
      ni.we    = eg_dm && dwe;
      ni.addr  = eg_dm ? daddr : iaddr;
      ni.size  = eg_dm ? dsize : 2'b11;
      ni.wdata = ni.we ? dwdata : 32'd0;
      lg       = legal(ni.addr, ni.size);
      ni.v     = lg;
      nr.dm    = eg_dm;
      nr.err   = !lg;
      nr.rdata = (!lg || ni.we) ? 32'd0 : rd(1'b1, ni.addr, ni.size);
    end

    @(posedge clk);
    t++;
    if (rst) begin
      q.delete();
      streak  = 0;
      iss     = '0;
      last_if = 32'd0;
      last_dm = 32'd0;
    end else begin
      if (eg_if || eg_dm) begin
        nr.due = t + 1;
        q.push_back(nr);
      end
      iss = (eg_if || eg_dm) ? ni : iss_t'('0);
      if (eg_if) streak = 0;
      else if (ireq && streak < LIMIT) streak++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rst);
    cycle(rst, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
  endtask

  function automatic logic [31:0] pick_addr();
    int unsigned r;
    r = $urandom % 16;
    if (r < 10)      return OFFSET + ($urandom % 32);
    else if (r < 13) return OFFSET + DEPTH - 8 + ($urandom % 16);
    else if (r < 15) return OFFSET - 1 - ($urandom % 4);
    else             return 32'h00001000;
  endfunction

  logic [4:0]  gv_if, gv_dm;
  logic        r_if_req, r_dm_req, r_dm_we, rst_r;
  logic [31:0] r_if_addr, r_dm_addr, r_dm_wdata;
  logic [1:0]  r_dm_size;
  int unsigned k0;

  initial begin
    mem_data_out = 32'd0;
    for (int i = 0; i < 64; i++) begin
      k0 = OFFSET + 32'(i);
      shadow[k0] = 8'($urandom);
      mem[k0]    = shadow[k0];
      k0 = OFFSET + DEPTH - 16 + 32'(i % 16);
      shadow[k0] = 8'($urandom);
      mem[k0]    = shadow[k0];
    end
    wr(1'b1, OFFSET, 2'b11, 32'h11223344);
    wr(1'b0, OFFSET, 2'b11, 32'h11223344);
    wr(1'b1, OFFSET + 16, 2'b01, 32'h77);
    wr(1'b0, OFFSET + 16, 2'b01, 32'h77);

    idle(1'b1);
    idle(1'b1);
    chk("reset_rvalid", if_rvalid, 1'b0);
    chk("reset_mem_size", mem_access_size, 2'b11);
    chk("reset_mem_addr", mem_address, 32'd0);

    // Fetch of a known big-endian word.
    cycle(1'b0, 1'b1, OFFSET, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
    chk("fetch_gnt", seen_if_gnt, 1'b1);
    idle(1'b0);
    chk("fetch_rvalid", if_rvalid, 1'b1);
    chk("fetch_rdata", if_rdata, 32'h11223344);
    chk("fetch_err", if_err, 1'b0);

    // Byte write then byte read back.
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, OFFSET + 5, 32'h000000AB, 2'b01);
    idle(1'b0);
    chk("bw_done", dm_done, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, OFFSET + 5, 32'd0, 2'b01);
    idle(1'b0);
    chk("br_done", dm_done, 1'b1);
    chk("br_rdata", dm_rdata, 32'h000000AB);

    // Sustained contention: dm,dm,dm,if,dm.
    gv_if = '0;
    gv_dm = '0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, (i < 4) ? OFFSET + 4 : OFFSET + 8, 1'b1, 1'b0,
            OFFSET + 32'(4 * i), 32'd0, 2'b11);
      gv_if = {gv_if[3:0], seen_if_gnt};
      gv_dm = {gv_dm[3:0], seen_dm_gnt};
    end
    chk("contend_if", 32'(gv_if), 32'(5'b00010));
    chk("contend_dm", 32'(gv_dm), 32'(5'b11101));
    idle(1'b0);
    idle(1'b0);

    // Illegal requests: misaligned word read and out-of-window fetch.
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, OFFSET + 2, 32'd0, 2'b11);
    cycle(1'b0, 1'b1, 32'h00001000, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
    chk("ill_dm_done", dm_done, 1'b1);
    chk("ill_dm_err", dm_err, 1'b1);
    chk("ill_dm_rdata", dm_rdata, 32'd0);
    chk("ill_mem_addr", mem_address, 32'd0);
    chk("ill_mem_we", mem_write_enable, 1'b0);
    idle(1'b0);
    chk("ill_if_rvalid", if_rvalid, 1'b1);
    chk("ill_if_err", if_err, 1'b1);
    chk("ill_if_rdata", if_rdata, 32'd0);

    // Pipelined fetch then data read.
    cycle(1'b0, 1'b1, OFFSET, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, OFFSET + 4, 32'd0, 2'b11);
    chk("pipe_c2_rvalid", if_rvalid, 1'b1);
    chk("pipe_c2_done", dm_done, 1'b0);
    idle(1'b0);
    chk("pipe_c3_rvalid", if_rvalid, 1'b0);
    chk("pipe_c3_done", dm_done, 1'b1);
    idle(1'b0);
    chk("pipe_c4_done", dm_done, 1'b0);

    // Reset during the issue cycle of a write.
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, OFFSET + 16, 32'h0000005A, 2'b01);
    idle(1'b1);
    idle(1'b0);
    chk("rst_wr_done1", dm_done, 1'b0);
    idle(1'b0);
    chk("rst_wr_done2", dm_done, 1'b0);
    chk("rst_wr_byte", 32'(mem[OFFSET + 16]), 32'h77);

    // Randomized traffic with request holding until granted.
    r_if_req = 1'b0;
    r_dm_req = 1'b0;
    r_if_addr = 32'd0; r_dm_addr = 32'd0; r_dm_wdata = 32'd0; r_dm_we = 1'b0; r_dm_size = 2'b11;
    seen_if_gnt = 1'b0;
    seen_dm_gnt = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!r_if_req || seen_if_gnt) begin
        r_if_req  = ($urandom % 4) != 0;
        r_if_addr = (($urandom % 4) == 0) ? pick_addr() : OFFSET + 32'(4 * ($urandom % 16));
      end
      if (!r_dm_req || seen_dm_gnt) begin
        r_dm_req   = ($urandom % 3) != 0;
        r_dm_we    = 1'($urandom % 2);
        r_dm_size  = (($urandom % 8) == 0) ? 2'b00 : 2'(1 + ($urandom % 3));
        r_dm_addr  = pick_addr();
        if (($urandom % 2) == 0) r_dm_addr = r_dm_addr & ~32'(nbytes(r_dm_size) - 1);
        r_dm_wdata = $urandom;
      end
      rst_r = ($urandom % 250) == 0;
      cycle(rst_r, r_if_req, r_if_addr, r_dm_req, r_dm_we, r_dm_addr, r_dm_wdata, r_dm_size);
    end
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
